pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid.sv | 33 +++
 rtl/pipe_stage_reg.sv | 114 +++++++++++
 tb/tb_pipe_stage_reg.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CTRL_W_DEF = 10;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       aluSrc;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
  } ctrl_t;

  localparam ctrl_t NOP = '0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/pipe_skid.sv
// One-entry skid buffer holding a combined {ctrl, data} beat.
module pipe_skid #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with stall, flush and a saturating flush counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer and register-only in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = DATA_W_DEF,
  parameter int unsigned       NWORDS      = 5,
  parameter int unsigned       CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(NOP)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NWORDS*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NWORDS*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [15:0]              flush_cnt
);
  localparam int unsigned PW = NWORDS * DATA_W;

  logic              r_valid;
  logic [PW-1:0]     r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [15:0]       r_flush_cnt;

  logic              w_valid_d;
  logic [PW-1:0]     w_data_d;
  logic [CTRL_W-1:0] w_ctrl_d;
  logic [15:0]       w_cnt_d;
  logic              w_accept;
  logic              w_drain;
  logic              w_occupied;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_valid & out_ready & ~stall & ~flush;

`ifdef PIPE_SKID_EN
  logic                     w_skid_valid;
  logic                     w_skid_load;
  logic                     w_skid_pop;
  logic [CTRL_W+PW-1:0]     w_skid_q;

  assign in_ready    = ~w_skid_valid & ~stall & ~flush & ~reset;
  assign w_skid_load = w_accept & r_valid & ~w_drain;
  assign w_skid_pop  = w_drain & w_skid_valid;
  assign w_occupied  = r_valid | w_skid_valid;

  pipe_skid #(.WIDTH(CTRL_W + PW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_data  ({in_ctrl, in_data}),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_q)
  );
`else
  assign in_ready   = (~r_valid | out_ready) & ~stall & ~flush & ~reset;
  assign w_occupied = r_valid;
`endif

  // Priority: flush, then skid refill, then direct load, then plain drain.
  always_comb begin
    w_valid_d = r_valid;
    w_data_d  = r_data;
    w_ctrl_d  = r_ctrl;
    w_cnt_d   = r_flush_cnt;
    if (flush) begin
      w_valid_d = 1'b0;
      w_ctrl_d  = CTRL_BUBBLE;
      if (w_occupied) w_cnt_d = sat_inc16(r_flush_cnt);
    end
`ifdef PIPE_SKID_EN
    else if (w_skid_pop) begin
      w_valid_d            = 1'b1;
      {w_ctrl_d, w_data_d} = w_skid_q;
    end
`endif
    else if (w_accept && (!r_valid || w_drain)) begin
      w_valid_d = 1'b1;
      w_data_d  = in_data;
      w_ctrl_d  = in_ctrl;
    end else if (w_drain) begin
      w_valid_d = 1'b0;
      w_ctrl_d  = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_ctrl      <= CTRL_BUBBLE;
      r_flush_cnt <= '0;
    end else begin
      r_valid     <= w_valid_d;
      r_data      <= w_data_d;
      r_ctrl      <= w_ctrl_d;
      r_flush_cnt <= w_cnt_d;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ctrl  = r_ctrl;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 5;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = NW * DW;

  logic          clk = 1'b0;
  logic          reset, stall, flush, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [15:0]   flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .NWORDS(NW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .flush_cnt (flush_cnt)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [PW-1:0] d;
  } beat_t;

  beat_t         q[$];
  logic [PW-1:0] m_shown;
  int unsigned   m_cnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_data(input logic [15:0] w0);
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return {t[PW-1:16], w0};
  endfunction

  // Called at a falling edge; checks state, advances model across the next rising edge.
  task automatic step(input logic v, input logic [PW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic st, input logic fl);
    logic exp_rdy;
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; stall = st; flush = fl;
    #1;
`ifdef PIPE_SKID_EN
    exp_rdy = !st && !fl && (q.size() < 2);
`else
    exp_rdy = !st && !fl && (q.size() == 0 || ordy);
`endif
    chk("in_ready",  PW'(in_ready),  PW'(exp_rdy));
    chk("out_valid", PW'(out_valid), PW'(q.size() != 0));
    chk("out_data",  out_data,       m_shown);
    chk("out_ctrl",  PW'(out_ctrl),  PW'((q.size() != 0) ? q[0].c : CW'(NOP)));
    chk("flush_cnt", PW'(flush_cnt), PW'(m_cnt));
    if (fl) begin
      if (q.size() != 0) m_cnt = (m_cnt == 32'd65535) ? m_cnt : m_cnt + 1;
      q.delete();
    end else if (!st) begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (v && exp_rdy) q.push_back({c, d});
    end
    if (q.size() != 0) m_shown = q[0].d;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", PW'(out_valid), '0);
    chk("rst_out_data",  out_data,       '0);
    chk("rst_out_ctrl",  PW'(out_ctrl),  PW'(CW'(NOP)));
    chk("rst_flush_cnt", PW'(flush_cnt), '0);
    chk("rst_in_ready",  PW'(in_ready),  '0);
    q.delete(); m_cnt = 0; m_shown = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(negedge clk);
    apply_reset();

    // Back-to-back stream, one beat per cycle.
    step(1'b1, rnd_data(16'h0010), CW'($urandom), 1'b1, 1'b0, 1'b0);
    chk("req33_w0_a", PW'(out_data[15:0]), PW'(16'h0010));
    step(1'b1, rnd_data(16'h0012), CW'($urandom), 1'b1, 1'b0, 1'b0);
    chk("req33_w0_b", PW'(out_data[15:0]), PW'(16'h0012));
    step(1'b1, rnd_data(16'h0014), CW'($urandom), 1'b1, 1'b0, 1'b0);
    chk("req33_w0_c", PW'(out_data[15:0]), PW'(16'h0014));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Stall holds a valid beat even with out_ready high.
    step(1'b1, rnd_data(16'h0020), CW'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, rnd_data(16'h0022), CW'($urandom), 1'b1, 1'b1, 1'b0);
    chk("req34_hold", PW'(out_data[15:0]), PW'(16'h0020));
    chk("req34_cnt",  PW'(flush_cnt),      '0);

    // Flush wins over stall and a pending all-ones control beat.
    step(1'b1, rnd_data(16'h0024), 10'h3FF, 1'b1, 1'b1, 1'b1);
    chk("req35_valid", PW'(out_valid), '0);
    chk("req35_ctrl",  PW'(out_ctrl),  '0);
    chk("req35_cnt",   PW'(flush_cnt), PW'(16'd1));

    // Backpressure: skid absorbs the second beat, order kept on release.
    step(1'b1, rnd_data(16'h0030), CW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd_data(16'h0032), CW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd_data(16'h0034), CW'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 75, rnd_data(16'($urandom)), CW'($urandom),
           $urandom_range(99) < 65, $urandom_range(99) < 12, $urandom_range(99) < 6);

    // Preload the counter near its ceiling, then drive it into saturation.
    force dut.r_flush_cnt = 16'hFFF0;
    #1;
    release dut.r_flush_cnt;
    m_cnt = 32'h0000_FFF0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rnd_data(16'($urandom)), CW'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, rnd_data(16'($urandom)), CW'($urandom), 1'b0, 1'b0, 1'b1);
    end
    chk("sat_cnt", PW'(flush_cnt), PW'(16'hFFFF));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a transfer.
    step(1'b1, rnd_data(16'h0040), CW'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, rnd_data(16'h0042), CW'($urandom), 1'b0, 1'b0, 1'b0);
    apply_reset();
    step(1'b1, rnd_data(16'h0050), CW'($urandom), 1'b1, 1'b0, 1'b0);
    chk("post_rst_w0", PW'(out_data[15:0]), PW'(16'h0050));
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
